popcount_arbiter: RTL and testbench

POPCOUNT_ARBITER -- requirements
Module: popcount_arbiter

---
 rtl/popcount_arbiter.sv | 147 ++++++++++++++
 tb/tb_popcount_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_arbiter.sv
// rtl/popcount_arbiter.sv - round-robin arbiter sharing one population-count unit
//
// Grants one requester at a time, forwards its operand to an external
// population-count unit, waits for the result under a watchdog and returns
// the count (or a timeout error) to the granted requester.

module popcount_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                                 clk_i,
   input  logic                                 rst_n_i,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_operand_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   output logic [NUM_REQ-1:0]                   rsp_valid_o,
   input  logic [NUM_REQ-1:0]                   rsp_ready_i,
   output logic [$clog2(DATA_WIDTH):0]          rsp_count_o,
   output logic                                 rsp_error_o,
   output logic                                 pc_data_valid_o,
   output logic [DATA_WIDTH-1:0]                pc_operand_o,
   input  logic                                 pc_idle_i,
   input  logic                                 pc_data_valid_i,
   input  logic [$clog2(DATA_WIDTH):0]          pc_pop_count_i,
   output logic                                 busy_o
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int IDX_W1 = IDX_W + 1;
   localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
   localparam int WD_W   = $clog2(TIMEOUT);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   NUM_REQ_X = IDX_W1'(NUM_REQ);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]            state_q;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [IDX_W-1:0]      tag_q;
   logic [DATA_WIDTH-1:0] operand_q;
   logic [CNT_W-1:0]      count_q;
   logic                  error_q;
   logic [WD_W-1:0]       wd_q;

   logic                  grant_found;
   logic [IDX_W-1:0]      grant_idx;
   logic [IDX_W:0]        cand;
   logic                  grant_en;
   logic                  rsp_ack;
   logic                  unit_done;

   // Search requesters starting at rr_ptr, wrapping, for the first valid one
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + IDX_W1'(i);
         if (cand >= NUM_REQ_X) begin
            cand = cand - NUM_REQ_X;
         end
         if (!grant_found && req_valid_i[cand[IDX_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Reset gates the grant so no accept strobe leaks out while rst_n_i is low
   assign grant_en  = rst_n_i && (state_q == S_IDLE) && pc_idle_i && grant_found;
   assign rsp_ack   = (state_q == S_RESP) && rsp_ready_i[tag_q];
   assign unit_done = pc_idle_i && pc_data_valid_i;

   // One-hot accept strobe and result-valid decode
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (grant_en) begin
         req_ready_o[grant_idx] = 1'b1;
      end
      if (state_q == S_RESP) begin
         rsp_valid_o[tag_q] = 1'b1;
      end
   end

   assign pc_data_valid_o = (state_q == S_ISSUE);
   assign pc_operand_o    = operand_q;
   assign rsp_count_o     = count_q;
   assign rsp_error_o     = error_q;
   assign busy_o          = (state_q != S_IDLE);

   // Job FSM: grant, start the unit, wait under watchdog, hold the response
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         tag_q     <= '0;
         operand_q <= '0;
         count_q   <= '0;
         error_q   <= 1'b0;
         wd_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_en) begin
                  operand_q <= req_operand_i[grant_idx];
                  tag_q     <= grant_idx;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wd_q    <= '0;
               state_q <= S_BUSY;
            end
            S_BUSY: begin
               wd_q <= wd_q + WD_W'(1);
               // A result arriving on the last watchdog cycle still wins
               if (unit_done) begin
                  count_q <= pc_pop_count_i;
                  error_q <= 1'b0;
                  state_q <= S_RESP;
               end else if (wd_q == WD_LAST) begin
                  count_q <= '0;
                  error_q <= 1'b1;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ack) begin
                  rr_ptr_q <= (tag_q == LAST_IDX) ? '0 : tag_q + IDX_W'(1);
                  state_q  <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb/tb_popcount_arbiter.sv - directed self-checking bench for popcount_arbiter

module tb_popcount_arbiter;

   localparam int L = 32 / 4 + 1;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req_valid;
   logic [3:0][31:0] req_operand;
   logic [3:0]       req_ready;
   logic [3:0]       rsp_valid;
   logic [3:0]       rsp_ready;
   logic [5:0]       rsp_count;
   logic             rsp_error;
   logic             pc_dv_o;
   logic [31:0]      pc_operand;
   logic             pc_idle;
   logic             pc_dv_i;
   logic [5:0]       pc_count;
   logic             busy;

   logic             hold_busy;
   logic             hang;

   logic             m_idle  = 1'b1;
   logic             m_busy  = 1'b0;
   logic             m_hung  = 1'b0;
   logic             m_valid = 1'b0;
   logic [5:0]       m_res   = 6'd0;
   int               m_rem   = 0;

   int               checks   = 0;
   int               failures = 0;
   int               rr_cnt [4] = '{1, 2, 3, 4};
   int               n;
   logic             seen;

   assign pc_idle  = m_idle & ~hold_busy;
   assign pc_dv_i  = m_valid;
   assign pc_count = m_res;

   popcount_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (32),
      .TIMEOUT    (64)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .req_valid_i     (req_valid),
      .req_operand_i   (req_operand),
      .req_ready_o     (req_ready),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .rsp_count_o     (rsp_count),
      .rsp_error_o     (rsp_error),
      .pc_data_valid_o (pc_dv_o),
      .pc_operand_o    (pc_operand),
      .pc_idle_i       (pc_idle),
      .pc_data_valid_i (pc_dv_i),
      .pc_pop_count_i  (pc_count),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit model: result L cycles after the start strobe, or never while hang is set
   always begin
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (pc_dv_o && !m_busy) begin
         m_busy = 1'b1;
         m_idle = 1'b0;
         m_rem  = L;
         m_res  = 6'($countones(pc_operand));
         m_hung = hang;
      end else if (m_busy) begin
         if (m_hung) begin
            if (!hang) begin
               m_busy = 1'b0;
               m_idle = 1'b1;
               m_hung = 1'b0;
            end
         end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_busy  = 1'b0;
               m_idle  = 1'b1;
               m_valid = 1'b1;
            end
         end
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic to_check();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag);
      int k = 0;
      while (req_ready == 4'b0 && k < 100) begin
         to_drive();
         to_check();
         k++;
      end
      check({tag, "_grant_seen"}, 64'(req_ready != 4'b0), 64'd1);
   endtask

   task automatic wait_rsp(input string tag);
      int k = 0;
      while (rsp_valid == 4'b0 && k < 100) begin
         to_drive();
         to_check();
         k++;
      end
      check({tag, "_rsp_seen"}, 64'(rsp_valid != 4'b0), 64'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 4'b1111;
      req_operand = '0;
      rsp_ready   = 4'b1111;
      hold_busy   = 1'b0;
      hang        = 1'b0;

      // Reset state: outputs quiet even with every request raised
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_pc_dv", 64'(pc_dv_o), 64'h0);
      check("rst_pc_operand", 64'(pc_operand), 64'h0);
      check("rst_count", 64'(rsp_count), 64'h0);
      check("rst_error", 64'(rsp_error), 64'h0);

      // Round-robin with all four requesting
      to_drive();
      rst_n          = 1'b1;
      req_operand[0] = 32'h1;
      req_operand[1] = 32'h3;
      req_operand[2] = 32'h7;
      req_operand[3] = 32'hF;
      to_check();
      for (int k = 0; k < 5; k++) begin
         wait_grant("rr");
         check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         wait_rsp("rr");
         check("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
         check("rr_count", 64'(rsp_count), 64'(rr_cnt[k % 4]));
         check("rr_error", 64'(rsp_error), 64'h0);
      end

      // Single job with wrap from rr_ptr=1 back to requester 0
      to_drive();
      req_valid      = 4'b0001;
      req_operand[0] = 32'hFFFF_FFFF;
      to_check();
      check("single_grant_c0", 64'(req_ready), 64'h1);
      for (int c = 1; c <= 12; c++) begin
         to_drive();
         if (c == 1) req_valid = 4'b0000;
         to_check();
         if (c == 1) begin
            check("single_pc_dv_c1", 64'(pc_dv_o), 64'h1);
            check("single_pc_operand_c1", 64'(pc_operand), 64'hFFFF_FFFF);
         end
         if (c == 2)  check("single_pc_dv_c2", 64'(pc_dv_o), 64'h0);
         if (c == 10) check("single_rsp_c10", 64'(rsp_valid), 64'h0);
         if (c == 11) begin
            check("single_rsp_c11", 64'(rsp_valid), 64'h1);
            check("single_count_c11", 64'(rsp_count), 64'd32);
            check("single_error_c11", 64'(rsp_error), 64'h0);
         end
         if (c == 12) check("single_idle_c12", 64'(busy), 64'h0);
      end

      // Backpressure on requester 2 while requester 0 keeps asking
      to_drive();
      req_valid      = 4'b0101;
      req_operand[2] = 32'hF0F0_F0F0;
      req_operand[0] = 32'h1;
      rsp_ready      = 4'b1011;
      to_check();
      check("bp_grant", 64'(req_ready), 64'h4);
      to_drive();
      req_valid = 4'b0001;
      to_check();
      wait_rsp("bp");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            to_drive();
            to_check();
         end
         check("bp_rsp_valid", 64'(rsp_valid), 64'h4);
         check("bp_count", 64'(rsp_count), 64'd16);
         check("bp_no_grant", 64'(req_ready), 64'h0);
      end
      to_drive();
      rsp_ready = 4'b1111;
      to_check();
      check("bp_handshake_valid", 64'(rsp_valid), 64'h4);
      check("bp_handshake_no_grant", 64'(req_ready), 64'h0);
      to_drive();
      to_check();
      check("bp_next_grant", 64'(req_ready), 64'h1);
      to_drive();
      req_valid = 4'b0000;
      to_check();
      wait_rsp("bp_next");
      check("bp_next_rsp", 64'(rsp_valid), 64'h1);
      check("bp_next_count", 64'(rsp_count), 64'd1);

      // Timeout: unit never completes
      to_drive();
      req_valid      = 4'b0010;
      req_operand[1] = 32'h3;
      hang           = 1'b1;
      to_check();
      check("to_grant", 64'(req_ready), 64'h2);
      for (int c = 1; c <= 65; c++) begin
         to_drive();
         if (c == 1) req_valid = 4'b0000;
         to_check();
      end
      check("to_no_rsp_c65", 64'(rsp_valid), 64'h0);
      check("to_busy_c65", 64'(busy), 64'h1);
      to_drive();
      to_check();
      check("to_rsp_c66", 64'(rsp_valid), 64'h2);
      check("to_count", 64'(rsp_count), 64'h0);
      check("to_error", 64'(rsp_error), 64'h1);
      to_drive();
      hang = 1'b0;
      to_check();
      check("to_back_idle", 64'(busy), 64'h0);

      // Reset pulse mid-BUSY
      to_drive();
      req_valid      = 4'b1000;
      req_operand[3] = 32'hF;
      to_check();
      check("mid_grant", 64'(req_ready), 64'h8);
      for (int c = 1; c <= 3; c++) begin
         to_drive();
         if (c == 1) req_valid = 4'b0000;
         to_check();
      end
      check("mid_busy_before", 64'(busy), 64'h1);
      to_drive();
      rst_n = 1'b0;
      to_check();
      check("mid_rst_busy", 64'(busy), 64'h0);
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("mid_rst_req_ready", 64'(req_ready), 64'h0);
      check("mid_rst_pc_dv", 64'(pc_dv_o), 64'h0);
      check("mid_rst_pc_operand", 64'(pc_operand), 64'h0);
      check("mid_rst_count", 64'(rsp_count), 64'h0);
      check("mid_rst_error", 64'(rsp_error), 64'h0);
      to_drive();
      rst_n     = 1'b1;
      req_valid = 4'b0110;
      to_check();
      n    = 0;
      seen = 1'b0;
      while (req_ready == 4'b0 && n < 40) begin
         if (rsp_valid != 4'b0) seen = 1'b1;
         to_drive();
         to_check();
         n++;
      end
      check("mid_no_rsp_after_rst", 64'(seen), 64'h0);
      check("mid_rr_ptr_zero_grant", 64'(req_ready), 64'h2);
      to_drive();
      req_valid = 4'b0000;
      to_check();
      wait_rsp("mid_next");
      check("mid_next_rsp", 64'(rsp_valid), 64'h2);
      check("mid_next_count", 64'(rsp_count), 64'd2);
      check("mid_next_error", 64'(rsp_error), 64'h0);

      // Unit not idle: hold off the grant until pc_idle_i rises
      to_drive();
      hold_busy      = 1'b1;
      req_valid      = 4'b0011;
      req_operand[0] = 32'h0000_00A5;
      to_check();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            to_drive();
            to_check();
         end
         check("ni_no_grant", 64'(req_ready), 64'h0);
         check("ni_idle", 64'(busy), 64'h0);
      end
      to_drive();
      hold_busy = 1'b0;
      to_check();
      check("ni_grant", 64'(req_ready), 64'h1);
      to_drive();
      req_valid = 4'b0000;
      to_check();
      wait_rsp("ni");
      check("ni_rsp", 64'(rsp_valid), 64'h1);
      check("ni_count", 64'(rsp_count), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
